multi_channel_timer: RTL and testbench
======================================

Name: multi_channel_timer

Overview:
Parametrised multi-channel timer/counter. One shared programmable prescaler drives CHANNELS independent counters. Each counter has a runtime-selectable mode (up, down, up/down triangle, one-shot), a programmable top, a compare value, a load strobe and a PWM output. It sits in the peripheral layer as the generic timing source for PWM, periodic interrupts and delays.

Parameters:
CHANNELS, 2, number of independent counter channels (>=1)
WIDTH, 16, counter/top/compare width in bits (>=2)
PRESCALE_WIDTH, 8, prescaler counter and divisor width (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
prescale  input  PRESCALE_WIDTH  divisor; tick every prescale+1 cycles
enable  input  CHANNELS  per-channel count enable
mode  input  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]
top  input  WIDTH*CHANNELS  per-channel top value, channel i at [WIDTH*i+:WIDTH]
compare  input  WIDTH*CHANNELS  per-channel compare value
load  input  CHANNELS  per-channel load strobe
load_value  input  WIDTH  value written by any asserted load bit
value  output  WIDTH*CHANNELS  current counter values
wrap  output  CHANNELS  one-cycle wrap/terminal pulse
match  output  CHANNELS  one-cycle compare-match pulse
pwm  output  CHANNELS  registered value<compare
done  output  CHANNELS  one-shot finished flag

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-high, and highest priority. Prescaler count=0, all value=0, direction=up, wrap=match=pwm=done=0.
- Prescaler: free-running count 0..prescale. tick=1 in the cycle count==prescale, and count returns to 0 on the next edge. prescale=0 gives tick every cycle. The prescaler runs regardless of enable. A prescale change takes effect immediately; if count>prescale, tick asserts and the count clears.
- Per channel, priority order: rst > load > (tick & enable & !done) update > hold.
- load[i]=1: value<=load_value, dir<=up, done<=0. No wrap or match pulse that cycle.
- Mode 00, up: value>=top gives value<=0 and wrap=1. Otherwise value+1.
- Mode 01, down: value==0 gives value<=top and wrap=1. value>top gives value<=top with no wrap. Otherwise value-1.
- Mode 10, up/down: dir up and value>=top gives dir<=down and value<=top-1. Dir down and value==0 gives dir<=up, value<=1 and wrap=1. Otherwise step in dir.
- Mode 11, one-shot: counts up. value>=top gives value<=top, done<=1 and wrap=1 once. While done=1 the channel holds until load or rst.
- top==0 in any mode: value<=0 and wrap=1 on every update.
- A mode change mid-count takes effect on the next update from the current value. Dir resets to up only via load or rst.
- wrap, match: registered pulses, high exactly one cycle, coincident with the edge that presents the new value. match=1 when an update (not load) produced new value==compare.
- pwm[i]: registered each cycle as (value_next < compare). compare=0 gives pwm always 0. compare>top in up mode gives pwm always 1.
- Arithmetic is modulo 2^WIDTH. Channels are fully independent apart from the shared tick and load_value.
- Disabled channel (enable=0): value, dir and done hold, and no pulses. Re-enabling resumes from the held value.

Test Plan:
1. CHANNELS=2, WIDTH=8. ch0 mode00, top=3, prescale=0, enable=1 -> value 0,1,2,3,0,...; wrap high on each edge where value becomes 0, period 4 cycles.
2. prescale=2, ch0 mode00, top=5, compare=2 -> value increments every 3 cycles; match pulses one cycle when value becomes 2; pwm=1 for values 0,1, else 0.
3. ch1 mode10, top=3 -> sequence 0,1,2,3,2,1,0,1...; wrap only on 0->1 turnarounds; ch0 unaffected by ch1 config.
4. ch0 mode11, top=4 -> counts to 4, done=1, single wrap pulse, value holds 4; load with load_value=0 -> done=0, counting restarts next tick.
5. Load mid-count: ch0 mode01, top=10, value=6, load=1 with load_value=9 -> value=9 next edge, no wrap/match; then counts 8,7...
6. rst asserted mid-count with load and tick active the same cycle -> next edge all values 0, all flags 0, prescaler restarts at 0; enable=0 thereafter -> value holds at 0.

Source files
------------

// File: rtl/multi_channel_timer.sv
// Multi-channel timer/counter: one shared prescaler drives CHANNELS independent
// counters. Each counter has a runtime mode (up, down, triangle, one-shot), a top
// value, a compare value, a load strobe, and registered wrap/match/pwm/done outputs.
module multi_channel_timer #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PRESCALE_WIDTH-1:0]   prescale,
  input  logic [CHANNELS-1:0]         enable,
  input  logic [2*CHANNELS-1:0]       mode,
  input  logic [WIDTH*CHANNELS-1:0]   top,
  input  logic [WIDTH*CHANNELS-1:0]   compare,
  input  logic [CHANNELS-1:0]         load,
  input  logic [WIDTH-1:0]            load_value,
  output logic [WIDTH*CHANNELS-1:0]   value,
  output logic [CHANNELS-1:0]         wrap,
  output logic [CHANNELS-1:0]         match,
  output logic [CHANNELS-1:0]         pwm,
  output logic [CHANNELS-1:0]         done
);

  localparam logic [1:0] ModeUp      = 2'b00;
  localparam logic [1:0] ModeDown    = 2'b01;
  localparam logic [1:0] ModeUpDown  = 2'b10;
  localparam logic [1:0] ModeOneShot = 2'b11;

  logic [PRESCALE_WIDTH-1:0]       pre_count_q, pre_count_d;
  logic                            tick;

  logic [CHANNELS-1:0][WIDTH-1:0]  value_q, value_d;
  // dir: 0 = counting up, 1 = counting down (triangle mode only)
  logic [CHANNELS-1:0]             dir_q, dir_d;
  logic [CHANNELS-1:0]             done_q, done_d;
  logic [CHANNELS-1:0]             wrap_q, wrap_d;
  logic [CHANNELS-1:0]             match_q, match_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;

  // Prescaler: >= rather than == so a divisor lowered below the count still ticks and clears.
  always_comb begin
    tick        = (pre_count_q >= prescale);
    pre_count_d = tick ? '0 : pre_count_q + PRESCALE_WIDTH'(1);
  end

  // Per-channel next-state: load beats a counting update, otherwise hold.
  always_comb begin
    value_d = value_q;
    dir_d   = dir_q;
    done_d  = done_q;
    wrap_d  = '0;
    match_d = '0;
    pwm_d   = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (load[i]) begin
        value_d[i] = load_value;
        dir_d[i]   = 1'b0;
        done_d[i]  = 1'b0;
      end else if (tick && enable[i] && !done_q[i]) begin
        if (top[WIDTH*i +: WIDTH] == '0) begin
          value_d[i] = '0;
          wrap_d[i]  = 1'b1;
        end else begin
          case (mode[2*i +: 2])
            ModeUp: begin
              if (value_q[i] >= top[WIDTH*i +: WIDTH]) begin
                value_d[i] = '0;
                wrap_d[i]  = 1'b1;
              end else begin
                value_d[i] = value_q[i] + WIDTH'(1);
              end
            end
            ModeDown: begin
              if (value_q[i] == '0) begin
                value_d[i] = top[WIDTH*i +: WIDTH];
                wrap_d[i]  = 1'b1;
              end else if (value_q[i] > top[WIDTH*i +: WIDTH]) begin
                // Top lowered beneath the count: snap to top silently.
                value_d[i] = top[WIDTH*i +: WIDTH];
              end else begin
                value_d[i] = value_q[i] - WIDTH'(1);
              end
            end
            ModeUpDown: begin
              if (!dir_q[i] && (value_q[i] >= top[WIDTH*i +: WIDTH])) begin
                dir_d[i]   = 1'b1;
                value_d[i] = top[WIDTH*i +: WIDTH] - WIDTH'(1);
              end else if (dir_q[i] && (value_q[i] == '0)) begin
                dir_d[i]   = 1'b0;
                value_d[i] = WIDTH'(1);
                wrap_d[i]  = 1'b1;
              end else if (dir_q[i]) begin
                value_d[i] = value_q[i] - WIDTH'(1);
              end else begin
                value_d[i] = value_q[i] + WIDTH'(1);
              end
            end
            ModeOneShot: begin
              if (value_q[i] >= top[WIDTH*i +: WIDTH]) begin
                value_d[i] = top[WIDTH*i +: WIDTH];
                done_d[i]  = 1'b1;
                wrap_d[i]  = 1'b1;
              end else begin
                value_d[i] = value_q[i] + WIDTH'(1);
              end
            end
            default: begin
              value_d[i] = value_q[i];
            end
          endcase
        end
        match_d[i] = (value_d[i] == compare[WIDTH*i +: WIDTH]);
      end
      pwm_d[i] = (value_d[i] < compare[WIDTH*i +: WIDTH]);
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_count_q <= '0;
      value_q     <= '0;
      dir_q       <= '0;
      done_q      <= '0;
      wrap_q      <= '0;
      match_q     <= '0;
      pwm_q       <= '0;
    end else begin
      pre_count_q <= pre_count_d;
      value_q     <= value_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      match_q     <= match_d;
      pwm_q       <= pwm_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;
  assign match = match_q;
  assign pwm   = pwm_q;
  assign done  = done_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer (2 channels, 8-bit). Stimulus sets inputs on
// the falling edge and queues the hand-computed outputs for the following rising edge;
// a monitor pops one entry per rising edge and compares.
module tb_multi_channel_timer;

  localparam int unsigned CHANNELS       = 2;
  localparam int unsigned WIDTH          = 8;
  localparam int unsigned PRESCALE_WIDTH = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [CHANNELS-1:0]       enable;
  logic [2*CHANNELS-1:0]     mode;
  logic [WIDTH*CHANNELS-1:0] top;
  logic [WIDTH*CHANNELS-1:0] compare;
  logic [CHANNELS-1:0]       load;
  logic [WIDTH-1:0]          load_value;
  logic [WIDTH*CHANNELS-1:0] value;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       match;
  logic [CHANNELS-1:0]       pwm;
  logic [CHANNELS-1:0]       done;

  multi_channel_timer #(
    .CHANNELS      (CHANNELS),
    .WIDTH         (WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prescale  (prescale),
    .enable    (enable),
    .mode      (mode),
    .top       (top),
    .compare   (compare),
    .load      (load),
    .load_value(load_value),
    .value     (value),
    .wrap      (wrap),
    .match     (match),
    .pwm       (pwm),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         idx;
    logic [7:0] v0;
    logic [7:0] v1;
    logic [1:0] w;
    logic [1:0] m;
    logic [1:0] p;
    logic [1:0] d;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string test_name = "reset";
  int    step_idx = 0;

  // Queue the outputs expected after the next rising edge, then advance to the next falling edge.
  task automatic step(input logic [7:0] v0, input logic [7:0] v1, input logic [1:0] w,
                      input logic [1:0] m, input logic [1:0] p, input logic [1:0] d);
    exp_t e;
    e.name = test_name;
    e.idx  = step_idx;
    e.v0 = v0; e.v1 = v1; e.w = w; e.m = m; e.p = p; e.d = d;
    sb_q.push_back(e);
    step_idx++;
    @(negedge clk);
  endtask

  task automatic begin_test(input string n);
    test_name = n;
    step_idx  = 0;
  endtask

  // Monitor: outputs settle just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (value[7:0] !== e.v0 || value[15:8] !== e.v1 || wrap !== e.w || match !== e.m ||
            pwm !== e.p || done !== e.d) begin
          errors++;
          $display("FAIL %s[%0d]: got v0=%0d v1=%0d wrap=%b match=%b pwm=%b done=%b, need v0=%0d v1=%0d wrap=%b match=%b pwm=%b done=%b",
                   e.name, e.idx, value[7:0], value[15:8], wrap, match, pwm, done,
                   e.v0, e.v1, e.w, e.m, e.p, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; prescale = '0; enable = '0; mode = '0; top = '0; compare = '0;
    load = '0; load_value = '0;
    @(negedge clk);

    // Reset state
    step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    // 1: ch0 up, top=3, compare=2, tick every cycle
    begin_test("up_top3");
    rst = 1'b0; enable = 2'b01; mode = 4'b0000;
    top = {8'd0, 8'd3}; compare = {8'd2, 8'd2};
    step(1, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(2, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    step(3, 0, 2'b00, 2'b00, 2'b10, 2'b00);
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00);
    step(1, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(2, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    step(3, 0, 2'b00, 2'b00, 2'b10, 2'b00);
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00);

    // 2: prescale=2, top=5, compare=2; load 0 to restart
    begin_test("prescale2");
    prescale = 8'd2; top = {8'd0, 8'd5}; load = 2'b01; load_value = 8'd0;
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    load = 2'b00;
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(1, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(1, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(1, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(2, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    step(2, 0, 2'b00, 2'b00, 2'b10, 2'b00);
    step(2, 0, 2'b00, 2'b00, 2'b10, 2'b00);
    for (int k = 3; k <= 5; k++) begin
      step(8'(k), 0, 2'b00, 2'b00, 2'b10, 2'b00);
      step(8'(k), 0, 2'b00, 2'b00, 2'b10, 2'b00);
      step(8'(k), 0, 2'b00, 2'b00, 2'b10, 2'b00);
    end
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00);

    // 3: ch1 triangle top=3 alongside ch0 up top=5
    begin_test("updown");
    prescale = 8'd0; enable = 2'b11; mode = 4'b1000; top = {8'd3, 8'd5};
    step(1, 1, 2'b00, 2'b00, 2'b11, 2'b00);
    step(2, 2, 2'b00, 2'b11, 2'b00, 2'b00);
    step(3, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    step(4, 2, 2'b00, 2'b10, 2'b00, 2'b00);
    step(5, 1, 2'b00, 2'b00, 2'b10, 2'b00);
    step(0, 0, 2'b01, 2'b00, 2'b11, 2'b00);
    step(1, 1, 2'b10, 2'b00, 2'b11, 2'b00);
    step(2, 2, 2'b00, 2'b11, 2'b00, 2'b00);

    // 4: ch0 one-shot top=4, compare=3; ch1 disabled and holding
    begin_test("oneshot");
    enable = 2'b01; mode = 4'b1011; top = {8'd3, 8'd4}; compare = {8'd2, 8'd3};
    load = 2'b01; load_value = 8'd0;
    step(0, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    load = 2'b00;
    step(1, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    step(2, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    step(3, 2, 2'b00, 2'b01, 2'b00, 2'b00);
    step(4, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    step(4, 2, 2'b01, 2'b00, 2'b00, 2'b01);
    step(4, 2, 2'b00, 2'b00, 2'b00, 2'b01);
    step(4, 2, 2'b00, 2'b00, 2'b00, 2'b01);
    load = 2'b01;
    step(0, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    load = 2'b00;
    step(1, 2, 2'b00, 2'b00, 2'b01, 2'b00);

    // 5: ch0 down top=10, compare=8; load mid-count
    begin_test("down_load");
    mode = 4'b1001; top = {8'd3, 8'd10}; compare = {8'd2, 8'd8};
    load = 2'b01; load_value = 8'd7;
    step(7, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    load = 2'b00;
    step(6, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    load = 2'b01; load_value = 8'd9;
    step(9, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    load = 2'b00;
    step(8, 2, 2'b00, 2'b01, 2'b00, 2'b00);
    step(7, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    step(6, 2, 2'b00, 2'b00, 2'b01, 2'b00);

    // 6: reset with tick and load active, then hold, then top=0 on ch1
    begin_test("reset_mid");
    prescale = 8'd1;
    step(6, 2, 2'b00, 2'b00, 2'b01, 2'b00);
    rst = 1'b1; load = 2'b11; load_value = 8'd5; enable = 2'b11;
    step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0; load = 2'b00; enable = 2'b00;
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    enable = 2'b11; mode = 4'b0001; top = {8'd0, 8'd10};
    step(0, 0, 2'b00, 2'b00, 2'b11, 2'b00);
    step(10, 0, 2'b11, 2'b00, 2'b10, 2'b00);
    step(10, 0, 2'b00, 2'b00, 2'b10, 2'b00);
    step(9, 0, 2'b10, 2'b00, 2'b10, 2'b00);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left in scoreboard, need 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
